or1k_wb_ext_responder: RTL and testbench
========================================

# or1k_wb_ext_responder

Wishbone B3 slave that answers one tile's external bus (`wb_ext_*`) from an on-chip synchronous RAM. It is instantiated once per node beside the MPSoC top. It is the responder for the initiator traffic each tile drives off-chip, and it supports classic cycles and incrementing and wrapping bursts with zero-wait-state streaming. Out-of-range addresses are reported on the error line.

## Interface
- `AW`, 32: address width (byte address).
- `DW`, 32: data width; fixed at 32, so 4 select bits.
- `MEM_SIZE_BYTES`, 32768: RAM size; power of two, at least 64.
- `BASE_ADDR`, 32'h0: byte address of RAM word 0.
- `MEM_FILE`, "": optional `$readmemh` image; an empty string means no preload.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `wb_adr_i` in AW: byte address; bits [1:0] are ignored.
- `wb_dat_i` in DW: write data.
- `wb_sel_i` in 4: byte enables.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: write enable.
- `wb_cab_i` in 1: ignored.
- `wb_cti_i` in 3: cycle type identifier.
- `wb_bte_i` in 2: burst type extension.
- `wb_ack_o` out 1: acknowledge.
- `wb_rty_o` out 1: retry; constant 0.
- `wb_err_o` out 1: error.
- `wb_dat_o` out DW: read data.

## Operation
- `req = wb_cyc_i & wb_stb_i`.
- `off = wb_adr_i - BASE_ADDR`; the access is in range iff `off < MEM_SIZE_BYTES` (unsigned compare).
- FSM states: IDLE, CLASSIC, BURST, ERR.
- **IDLE**:
  - `req` and out of range → ERR.
  - `req` with `cti == 3'b010` → BURST; `burst_adr <= off`.
  - Any other `req` (cti 000, 001, 111, or reserved) → CLASSIC.
  - In all three `req` cases, the RAM read is issued at `off`.
- **CLASSIC**: `ack_q = 1` for exactly one cycle, then IDLE. A new request is not sampled until the cycle after the ack, so the minimum spacing is 2 cycles per access.
- **BURST**: `ack_q` stays 1.
  - On each beat with `wb_ack_o = 1`: `burst_adr <= nxt(burst_adr)`, and the RAM read is issued at `nxt(burst_adr)`.
  - Otherwise the read is reissued at `burst_adr`.
  - A beat acked with `cti == 3'b111` → IDLE.
  - `wb_cyc_i == 0` → IDLE.
- **ERR**: `wb_err_o = 1` for one cycle, then IDLE. The RAM is not accessed.
- `nxt(a)` by `wb_bte_i`, with `w` the wrap mask:
  - 00: linear, `a + 4`.
  - 01: `w = 16`.
  - 10: `w = 32`.
  - 11: `w = 64`.
  - Wrapping form: `(a & ~(w-1)) | ((a + 4) & (w-1))`.
  - A linear burst that runs past `MEM_SIZE_BYTES` wraps modulo the RAM size; no error is raised.
- Writes:
  - Performed in any cycle with `wb_ack_o & wb_we_i`.
  - Address is `wb_adr_i - BASE_ADDR`; only bytes with `wb_sel_i` set are written.
- `wb_dat_o` is RAM data registered from the read issued in the previous cycle. It is valid whenever `wb_ack_o` is 1 and `wb_we_i` is 0.

## Timing
- `wb_ack_o = ack_q & wb_cyc_i & wb_stb_i`: a strobe the master drops is never acked.
- `wb_err_o` is registered and gated the same way.
- Latency: first ack or err arrives 1 cycle after `req` is sampled in IDLE. A burst then delivers 1 beat per cycle while `wb_stb_i` is held.
- Master wait state during a burst (`stb = 0`):
  - `ack_o` goes to 0 combinationally.
  - `burst_adr` is held.
  - The next beat is acked in the first cycle `stb` returns.
- `wb_cyc_i` dropped mid-burst: no ack in that cycle; IDLE next cycle.
- Reset mid-operation: state IDLE, `ack_q` 0, `err` 0, `wb_dat_o` 0 immediately (asynchronous). RAM contents are preserved.
- Reset values: `wb_ack_o`, `wb_err_o`, `wb_rty_o` 0; `wb_dat_o` 0.

## Structure
- Shared package `or1k_wb_pkg` holds:
  - CTI constants CLASSIC=000, CONST=001, INCR=010, EOB=111.
  - BTE constants LINEAR, WRAP4, WRAP8, WRAP16.
  - The `wb_resp_state_t` enum.
- Sub-module `or1k_wb_ram`: single-port synchronous RAM.
  - Parameters DEPTH and MEM_FILE.
  - Ports: `clk`, `adr`, `we`, `sel[3:0]`, `din`, `dout` (registered).
  - Reads and writes share the port. A same-address read/write returns the old data, and the FSM never relies on write-through.

## Test plan
- Classic write `0x100 ← 0xDEADBEEF` with `sel = 4'hF`, then classic read of `0x100`:
  - `ack` appears 1 cycle after each `stb`.
  - Read returns `0xDEADBEEF`.
  - `ack` is low in the cycle after each ack.
- Preload words `0x0..0xC` = 0,1,2,3; WRAP4 read burst (`cti = 010`, `bte = 01`) at `0x8`, 4 beats, `cti = 111` on the last:
  - Data order 2,3,0,1.
  - 4 consecutive acks, then `ack = 0`.
- Linear 8-beat write burst from `0x40`, then read back:
  - Each beat lands at `0x40 + 4k`.
  - No gaps in `ack`.
- Read at `BASE_ADDR + MEM_SIZE_BYTES` → `err = 1` for one cycle, `ack = 0`, RAM unchanged. A subsequent valid read succeeds.
- Burst with `stb` low for 2 cycles after beat 2 → no acks during the stall; beat 3 data is correct on resume. Dropping `cyc` at beat 3 → ack stops at once and the FSM is in IDLE next cycle.
- Write `sel = 4'b0010` of `0xAABBCCDD` over `0x11111111` → reads `0x1111CC11`. Assert `rst` mid-burst → all outputs 0 within the same cycle, and the next classic read works.

Source files
------------

// File: rtl/or1k_wb_pkg.sv
// Shared Wishbone B3 encodings and responder state type for the or1k
// external-bus responder slice.
package or1k_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    RESP_IDLE    = 2'd0,
    RESP_CLASSIC = 2'd1,
    RESP_BURST   = 2'd2,
    RESP_ERR     = 2'd3
  } wb_resp_state_t;

endpackage

// File: rtl/or1k_wb_ram.sv
// Single-port synchronous RAM with byte enables and a registered read port.
// A read and write to the same word in one cycle returns the old data.
module or1k_wb_ram #(
  parameter int    DEPTH    = 8192,
  parameter string MEM_FILE = ""
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] adr,
  input  logic                     we,
  input  logic [3:0]               sel,
  input  logic [31:0]              din,
  output logic [31:0]              dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) mem[adr][8*b +: 8] <= din[8*b +: 8];
      end
    end
    dout <= mem[adr];
  end

endmodule

// File: rtl/or1k_wb_ext_responder.sv
// Wishbone B3 slave answering a tile's external bus from on-chip RAM:
// classic cycles, linear and wrapping bursts, error on out-of-range access.
module or1k_wb_ext_responder
  import or1k_wb_pkg::*;
#(
  parameter int             AW             = 32,
  parameter int             DW             = 32,
  parameter int             MEM_SIZE_BYTES = 32768,
  parameter logic [AW-1:0]  BASE_ADDR      = '0,
  parameter string          MEM_FILE       = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic          wb_cab_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic          wb_ack_o,
  output logic          wb_rty_o,
  output logic          wb_err_o,
  output logic [DW-1:0] wb_dat_o
);

  localparam int DEPTH = MEM_SIZE_BYTES / 4;
  localparam int MW    = $clog2(DEPTH);
  localparam int OW    = MW + 2;

  localparam logic [1:0] S_IDLE    = RESP_IDLE;
  localparam logic [1:0] S_CLASSIC = RESP_CLASSIC;
  localparam logic [1:0] S_BURST   = RESP_BURST;
  localparam logic [1:0] S_ERR     = RESP_ERR;

  logic [1:0]    state;
  logic          ack_q;
  logic          err_q;
  logic          dat_vld;
  logic [OW-1:0] burst_adr;
  logic [OW-1:0] burst_nxt;
  logic [OW-1:0] ram_byte;
  logic [AW-1:0] off;
  logic          req;
  logic          in_range;
  logic          ram_we;
  logic [MW-1:0] ram_adr;
  logic [31:0]   ram_dout;
  logic          unused_ok;

  // Byte offset of the next beat; linear bursts wrap at the RAM size by truncation.
  function automatic logic [OW-1:0] nxt_adr(input logic [OW-1:0] a, input logic [1:0] bte);
    logic [OW-1:0] m;
    logic [OW-1:0] inc;
    inc = a + OW'(4);
    case (bte)
      BTE_WRAP4:  m = OW'(15);
      BTE_WRAP8:  m = OW'(31);
      BTE_WRAP16: m = OW'(63);
      default:    m = '1;
    endcase
    return (a & ~m) | (inc & m);
  endfunction

  // Handshake: a beat completes in any cycle where wb_cyc_i, wb_stb_i and
  // ack_q are all high; dropping stb stalls a burst with its address held.
  assign req       = wb_cyc_i & wb_stb_i;
  assign off       = wb_adr_i - BASE_ADDR;
  assign in_range  = (off < AW'(MEM_SIZE_BYTES));
  assign wb_ack_o  = ack_q & req;
  assign wb_err_o  = err_q & req;
  assign wb_rty_o  = 1'b0;
  assign burst_nxt = nxt_adr(burst_adr, wb_bte_i);
  assign ram_we    = wb_ack_o & wb_we_i;

  always_comb begin
    ram_byte = off[OW-1:0];
    if (state == S_BURST && !ram_we) begin
      ram_byte = wb_ack_o ? burst_nxt : burst_adr;
    end
    ram_adr = ram_byte[OW-1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_vld   <= 1'b0;
      burst_adr <= '0;
    end else begin
      dat_vld <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (!in_range) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else if (wb_cti_i == CTI_INCR) begin
              state     <= S_BURST;
              ack_q     <= 1'b1;
              burst_adr <= off[OW-1:0];
            end else begin
              state <= S_CLASSIC;
              ack_q <= 1'b1;
            end
          end
        end
        S_CLASSIC: begin
          state <= S_IDLE;
          ack_q <= 1'b0;
        end
        S_BURST: begin
          if (!wb_cyc_i) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
          end else if (wb_ack_o) begin
            if (wb_cti_i == CTI_EOB) begin
              state <= S_IDLE;
              ack_q <= 1'b0;
            end else begin
              burst_adr <= burst_nxt;
            end
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  or1k_wb_ram #(
    .DEPTH    (DEPTH),
    .MEM_FILE (MEM_FILE)
  ) u_ram (
    .clk  (clk),
    .adr  (ram_adr),
    .we   (ram_we),
    .sel  (wb_sel_i),
    .din  (wb_dat_i),
    .dout (ram_dout)
  );

  // Read data is forced to zero from reset until the RAM register has been clocked.
  assign wb_dat_o = dat_vld ? ram_dout : '0;

  assign unused_ok = ^{wb_cab_i, ram_byte[1:0]};

endmodule

// File: tb/tb_or1k_wb_ext_responder.sv
// Scoreboard bench for or1k_wb_ext_responder: drivers push expected responses
// from a word-array model; a negedge monitor pops and compares them.
module tb_or1k_wb_ext_responder;
  import or1k_wb_pkg::*;

  localparam int          MEM   = 1024;
  localparam int          DEPTH = MEM / 4;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [1:0]  K_RD  = 2'd0;
  localparam logic [1:0]  K_WR  = 2'd1;
  localparam logic [1:0]  K_ERR = 2'd2;

  logic        clk, rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_cab_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o, wb_rty_o, wb_err_o;

  int          checks   = 0;
  int          failures = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  logic [31:0] model_mem [DEPTH];

  or1k_wb_ext_responder #(
    .AW(32), .DW(32), .MEM_SIZE_BYTES(MEM), .BASE_ADDR(BASE), .MEM_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_cab_i(wb_cab_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_ack_o(wb_ack_o), .wb_rty_o(wb_rty_o),
    .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference model helpers
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int beat_off(input int start, input int k, input logic [1:0] bte);
    int w;
    if (bte == BTE_LINEAR) return (start + 4 * k) % MEM;
    w = (bte == BTE_WRAP4) ? 16 : (bte == BTE_WRAP8) ? 32 : 64;
    return (start / w) * w + ((start % w) + 4 * k) % w;
  endfunction

  task automatic expect_beat(input bit we, input int off, input logic [31:0] d, input logic [3:0] s);
    if (we) begin
      model_mem[off / 4] = merge(model_mem[off / 4], d, s);
      exp_q.push_back({K_WR, 32'd0});
    end else begin
      exp_q.push_back({K_RD, model_mem[off / 4]});
    end
  endtask

  // driver tasks
  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR; wb_sel_i = 4'h0;
  endtask

  task automatic wait_resp(output int waited, output bit got);
    waited = 0;
    got = 1'b0;
    while (!got && waited < 8) begin
      @(negedge clk);
      waited++;
      got = (wb_ack_o === 1'b1) || (wb_err_o === 1'b1);
    end
  endtask

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    int          waited;
    bit          got;
    off = adr - BASE;
    if (off >= 32'(MEM)) exp_q.push_back({K_ERR, 32'd0});
    else expect_beat(we, int'(off), d, s);
    case ($urandom_range(0, 2))
      0:       wb_cti_i = CTI_CLASSIC;
      1:       wb_cti_i = CTI_CONST;
      default: wb_cti_i = CTI_EOB;
    endcase
    wb_adr_i = adr; wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
    wb_bte_i = 2'($urandom_range(0, 3)); wb_cab_i = 1'($urandom);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wait_resp(waited, got);
    if (!got) begin
      check("classic_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check("classic_latency", 32'(waited), 32'd2);
      @(negedge clk);
      check("classic_ack_gap", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic burst(input bit we, input int start, input int n, input logic [1:0] bte,
                       input int stall_at, input int drop_at, input bit rnd_sel);
    int          off, waited;
    bit          got;
    logic [31:0] d;
    logic [3:0]  s;
    for (int k = 0; k < n; k++) begin
      if (k == drop_at) begin
        wb_cyc_i = 1'b0;
        @(negedge clk);
        check("cyc_drop_no_ack", {31'd0, wb_ack_o}, 32'd0);
        @(posedge clk); #1;
        check("cyc_drop_idle", {30'd0, dut.state}, 32'(RESP_IDLE));
        idle_bus();
        @(posedge clk); #1;
        return;
      end
      off = beat_off(start, k, bte);
      d = $urandom;
      s = rnd_sel ? 4'($urandom_range(1, 15)) : 4'hF;
      wb_adr_i = BASE + 32'(off); wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
      wb_bte_i = bte; wb_cti_i = (k == n - 1) ? CTI_EOB : CTI_INCR;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      expect_beat(we, off, d, s);
      wait_resp(waited, got);
      if (!got) begin
        check("burst_timeout", 32'd0, 32'd1);
        void'(exp_q.pop_back());
        idle_bus();
        @(posedge clk); #1;
        return;
      end
      check("burst_beat_latency", 32'(waited), (k == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      if (k == stall_at && k < n - 1) begin
        wb_stb_i = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("stall_no_ack", {31'd0, wb_ack_o}, 32'd0);
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    check("burst_end_gap", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (wb_ack_o === 1'b1 || wb_err_o === 1'b1)) begin
      check("resp_gating", {30'd0, wb_ack_o & wb_err_o, ~(wb_cyc_i & wb_stb_i)}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_kind", {30'd0, wb_err_o, wb_ack_o}, (mon_e[33:32] == K_ERR) ? 32'd2 : 32'd1);
        if (mon_e[33:32] == K_RD && wb_ack_o) check("read_data", wb_dat_o, mon_e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    int waited;
    bit got;
    int n, st, stall, drop;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    idle_bus();
    wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_cab_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    check("reset_err", {31'd0, wb_err_o}, 32'd0);
    check("reset_rty", {31'd0, wb_rty_o}, 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // fill the whole RAM with one linear write burst
    burst(1'b1, 0, DEPTH, BTE_LINEAR, -1, -1, 1'b0);

    classic(1'b1, BASE + 32'h100, 32'hDEADBEEF, 4'hF);
    classic(1'b0, BASE + 32'h100, 32'd0, 4'hF);

    for (int i = 0; i < 4; i++) classic(1'b1, BASE + 32'(4 * i), 32'(i), 4'hF);
    burst(1'b0, 8, 4, BTE_WRAP4, -1, -1, 1'b0);

    burst(1'b1, 32'h40, 8, BTE_LINEAR, -1, -1, 1'b0);
    burst(1'b0, 32'h40, 8, BTE_LINEAR, -1, -1, 1'b0);

    classic(1'b0, BASE + 32'(MEM), 32'd0, 4'hF);
    classic(1'b1, BASE - 32'd4, 32'h12345678, 4'hF);
    classic(1'b0, BASE + 32'h100, 32'd0, 4'hF);

    burst(1'b0, 32'h40, 6, BTE_LINEAR, 1, -1, 1'b0);
    burst(1'b0, 32'h40, 6, BTE_LINEAR, -1, 3, 1'b0);

    classic(1'b1, BASE + 32'h200, 32'h11111111, 4'hF);
    classic(1'b1, BASE + 32'h200, 32'hAABBCCDD, 4'b0010);
    classic(1'b0, BASE + 32'h200, 32'd0, 4'hF);

    burst(1'b0, MEM - 8, 4, BTE_LINEAR, -1, -1, 1'b0);
    burst(1'b1, 32'h3C, 4, BTE_WRAP8, -1, -1, 1'b1);
    burst(1'b0, 32'h74, 8, BTE_WRAP16, 2, -1, 1'b0);

    // reset in the middle of a read burst
    wb_adr_i = BASE + 32'h40; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cti_i = CTI_INCR; wb_bte_i = BTE_LINEAR; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    expect_beat(1'b0, 32'h40, 32'd0, 4'hF);
    wait_resp(waited, got);
    check("rst_burst_first_latency", 32'(waited), 32'd2);
    @(posedge clk); #1;
    wb_adr_i = BASE + 32'h44;
    expect_beat(1'b0, 32'h44, 32'd0, 4'hF);
    wait_resp(waited, got);
    check("rst_burst_second_latency", 32'(waited), 32'd1);
    @(posedge clk); #1;
    wb_adr_i = BASE + 32'h48;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_mid_err", {31'd0, wb_err_o}, 32'd0);
    check("rst_mid_rty", {31'd0, wb_rty_o}, 32'd0);
    check("rst_mid_dat", wb_dat_o, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    classic(1'b0, BASE + 32'h100, 32'd0, 4'hF);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          if ($urandom_range(0, 7) == 0)
            classic(1'b1, BASE + 32'(MEM) + 32'(4 * $urandom_range(0, 15)), $urandom, 4'hF);
          else
            classic(1'b1, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        1: begin
          if ($urandom_range(0, 5) == 0)
            classic(1'b0, BASE - 32'(4 * $urandom_range(1, 4)), 32'd0, 4'hF);
          else
            classic(1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'd0, 4'hF);
        end
        default: begin
          n     = $urandom_range(2, 8);
          st    = 4 * $urandom_range(0, DEPTH - 1);
          stall = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 2) : -1;
          drop  = (stall < 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
          burst(1'($urandom), st, n, 2'($urandom_range(0, 3)), stall, drop, 1'($urandom));
        end
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_rty", {31'd0, wb_rty_o}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
